// File: rtl/cia_pkg.sv
// rtl/cia_pkg.sv - shared constants and types for the buffered CIA serial port
// Contents: REG_SDR register address and a default-width serial word type.
package cia_pkg;
  localparam logic [3:0] REG_SDR = 4'hC;
  localparam int DW_DEF = 8;
  typedef logic [DW_DEF-1:0] word_t;
endpackage

// File: rtl/cia_fifo.sv
// rtl/cia_fifo.sv - synchronous FIFO used for the serial port TX and RX queues
// Ports: clk, res (sync active-high), clr (sync flush), push/din, pop/dout,
//        empty, full. A push while full is dropped unless a pop happens in the
//        same cycle, in which case both take effect.
module cia_fifo
  import cia_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         res,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp, rp;
  logic         do_push, do_pop;

  assign empty   = (wp == rp);
  // extra pointer bit distinguishes full from empty when the indices match
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (res || clr) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/cia_serial_fifo.sv
// rtl/cia_serial_fifo.sv - buffered CIA serial data port with TX/RX FIFOs
// Ports: clk/res; phi2_up/phi2_dn strobes; we/re/addr/data register access;
//        txmode, lsb_first, ta_int, cnt_up, sp_in controls and pad inputs;
//        regs (SDR read value), cnt_out/sp_out pad drives, sp_int word pulse,
//        tx_empty, rx_full, overrun status.
module cia_serial_fifo
  import cia_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          res,
  input  logic          phi2_up,
  input  logic          phi2_dn,
  input  logic          we,
  input  logic          re,
  input  logic [3:0]    addr,
  input  logic [DW-1:0] data,
  input  logic          txmode,
  input  logic          lsb_first,
  input  logic          ta_int,
  input  logic          cnt_up,
  input  logic          sp_in,
  output logic [DW-1:0] regs,
  output logic          cnt_out,
  output logic          sp_out,
  output logic          sp_int,
  output logic          tx_empty,
  output logic          rx_full,
  output logic          overrun
);
  localparam int CW = $clog2(DW) + 1;

  logic          mode_q, clr, wr_sdr, rd_sdr;
  logic [DW-1:0] hold_q, last_rx_q;

  logic          tx_push, tx_pop, tx_fifo_empty, tx_fifo_full;
  logic [DW-1:0] tx_dout, tx_sh;
  logic [CW-1:0] tx_cnt;
  logic          tx_active, osc, tick, bit_clk, tx_done, tx_load;

  logic          rx_push, rx_pop, rx_fifo_empty, rx_sample, rx_done;
  logic [DW-1:0] rx_dout, rx_sh, rx_next;
  logic [CW-1:0] rx_cnt;

  assign clr    = phi2_dn & (txmode != mode_q);
  assign wr_sdr = phi2_dn & we & (addr == REG_SDR) & ~clr;
  assign rd_sdr = phi2_dn & re & (addr == REG_SDR) & ~clr;

  // Timer A underflows are aligned with the PHI2 rising edge.
  assign tick    = ta_int & phi2_up & txmode & (tx_active | osc);
  assign bit_clk = tick & ~osc;
  // A word ends on the CNT rising edge that samples its last bit, so the
  // next word's first bit is on SP before the following CNT fall.
  assign tx_done = tick & osc & (tx_cnt == CW'(DW));
  assign tx_load = txmode & phi2_up & ~clr & ~tx_fifo_empty & (~tx_active | tx_done);
  assign tx_push = wr_sdr & txmode & ~tx_fifo_full;
  assign tx_pop  = tx_load;

  assign rx_sample = phi2_up & cnt_up & ~txmode & ~clr;
  assign rx_next   = lsb_first ? {sp_in, rx_sh[DW-1:1]} : {rx_sh[DW-2:0], sp_in};
  assign rx_done   = rx_sample & (rx_cnt == CW'(DW - 1));
  assign rx_push   = rx_done;
  assign rx_pop    = rd_sdr & ~rx_fifo_empty;

  cia_fifo #(.W(DW), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .res(res), .clr(clr), .push(tx_push), .pop(tx_pop),
    .din(data), .dout(tx_dout), .empty(tx_fifo_empty), .full(tx_fifo_full)
  );

  cia_fifo #(.W(DW), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .res(res), .clr(clr), .push(rx_push), .pop(rx_pop),
    .din(rx_next), .dout(rx_dout), .empty(rx_fifo_empty), .full(rx_full)
  );

  // tx_cnt counts bit clocks in the current word; the first one only opens
  // the bit-0 period, every later one advances to the next bit.
  always_ff @(posedge clk) begin
    if (res || clr) begin
      osc       <= 1'b0;
      tx_active <= 1'b0;
      tx_sh     <= '0;
      tx_cnt    <= '0;
    end else begin
      if (tick) osc <= ~osc;
      if (tx_load) begin
        tx_active <= 1'b1;
        tx_sh     <= tx_dout;
        tx_cnt    <= '0;
      end else if (tx_done) begin
        tx_active <= 1'b0;
        tx_cnt    <= '0;
      end else if (bit_clk) begin
        tx_cnt <= tx_cnt + 1'b1;
        if (tx_cnt != '0) tx_sh <= lsb_first ? (tx_sh >> 1) : (tx_sh << 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res || clr) begin
      rx_sh  <= '0;
      rx_cnt <= '0;
    end else if (rx_sample) begin
      rx_sh  <= rx_next;
      rx_cnt <= rx_done ? '0 : rx_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      mode_q    <= 1'b0;
      hold_q    <= '0;
      last_rx_q <= '0;
      sp_int    <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (phi2_dn) mode_q <= txmode;
      if (clr) begin
        hold_q    <= '0;
        last_rx_q <= '0;
        sp_int    <= 1'b0;
      end else begin
        if (wr_sdr)  hold_q    <= data;
        if (rx_pop)  last_rx_q <= rx_dout;
        if (phi2_up) sp_int    <= tx_done | rx_done;
      end
      // overrun survives a mode change; only a read clears it
      if (rx_done & rx_full & ~rx_pop) overrun <= 1'b1;
      else if (rd_sdr)                 overrun <= 1'b0;
    end
  end

  assign regs     = txmode ? hold_q : (rx_fifo_empty ? last_rx_q : rx_dout);
  assign cnt_out  = txmode ? ~osc : 1'b1;
  assign sp_out   = (txmode & tx_active) ? (lsb_first ? tx_sh[0] : tx_sh[DW-1]) : 1'b1;
  assign tx_empty = tx_fifo_empty & ~tx_active;
endmodule
